// File: rtl/exibe_sequencia.sv
// Plays the stored LED sequence from address 0 to a latched limit,
// lighting each item for TEMPO_ACESO cycles then blanking TEMPO_APAGADO.
//
// Ports:
//   clock     : rising-edge system clock
//   reset     : asynchronous active-low reset
//   iniciar   : start request, sampled only while idle
//   limite    : index of last item, latched on start
//   dado      : memory read data for endereco
//   endereco  : memory read address
//   leds      : LED drive, dado while lit, 0 otherwise
//   ocupado   : high whenever not idle
//   pronto    : one-cycle pulse at end of playback
//   db_estado : current state code for debug display
module exibe_sequencia #(
  parameter int TEMPO_ACESO   = 500,
  parameter int TEMPO_APAGADO = 250,
  parameter int ADDR_W        = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [3:0]        dado,
  output logic [ADDR_W-1:0] endereco,
  output logic [3:0]        leds,
  output logic              ocupado,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam int TMAX =
    (TEMPO_ACESO > TEMPO_APAGADO) ? TEMPO_ACESO : TEMPO_APAGADO;
  localparam int TW = $clog2(TMAX) + 1;

  localparam logic [TW-1:0] ULT_ACESO   = TW'(TEMPO_ACESO - 1);
  localparam logic [TW-1:0] ULT_APAGADO = TW'(TEMPO_APAGADO - 1);

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    PREPARA = 4'd1,
    ACENDE  = 4'd2,
    APAGA   = 4'd3,
    PROXIMO = 4'd4,
    FIM     = 4'd5
  } estado_t;

  estado_t           estado_q;
  logic [ADDR_W-1:0] end_q;
  logic [ADDR_W-1:0] lim_q;
  logic [TW-1:0]     timer_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= INICIAL;
      end_q    <= '0;
      lim_q    <= '0;
      timer_q  <= '0;
    end else begin
      case (estado_q)
        INICIAL: begin
          timer_q <= '0;
          if (iniciar) begin
            lim_q    <= limite;
            estado_q <= PREPARA;
          end
        end
        PREPARA: begin
          end_q    <= '0;
          timer_q  <= '0;
          estado_q <= ACENDE;
        end
        ACENDE: begin
          if (timer_q == ULT_ACESO) begin
            timer_q  <= '0;
            estado_q <= APAGA;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        APAGA: begin
          if (timer_q == ULT_APAGADO) begin
            timer_q <= '0;
            // Last item reached before the address could wrap
            if (end_q == lim_q) estado_q <= FIM;
            else                estado_q <= PROXIMO;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        PROXIMO: begin
          end_q    <= end_q + 1'b1;
          timer_q  <= '0;
          estado_q <= ACENDE;
        end
        FIM: begin
          timer_q  <= '0;
          estado_q <= INICIAL;
        end
        default: begin
          timer_q  <= '0;
          estado_q <= INICIAL;
        end
      endcase
    end
  end

  // dado arrives combinationally for end_q, so leds must follow it
  // within the same cycle rather than through another register.
  assign endereco  = end_q;
  assign leds      = (estado_q == ACENDE) ? dado : 4'b0000;
  assign ocupado   = (estado_q != INICIAL);
  assign pronto    = (estado_q == FIM);
  assign db_estado = estado_q;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Directed bench for exibe_sequencia with short on/off times.
// Memory model feeds dado combinationally from endereco.
module tb_exibe_sequencia;

  localparam int TA = 3;
  localparam int TP = 2;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic [3:0] limite;
  logic [3:0] dado;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       ocupado;
  logic       pronto;
  logic [3:0] db_estado;

  int total;
  int bad;
  int cyc;

  exibe_sequencia #(
    .TEMPO_ACESO  (TA),
    .TEMPO_APAGADO(TP),
    .ADDR_W       (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .iniciar  (iniciar),
    .limite   (limite),
    .dado     (dado),
    .endereco (endereco),
    .leds     (leds),
    .ocupado  (ocupado),
    .pronto   (pronto),
    .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [3:0] mem(input logic [3:0] a);
    case (a)
      4'd0:    mem = 4'b1000;
      4'd1:    mem = 4'b0100;
      4'd2:    mem = 4'b0010;
      4'd3:    mem = 4'b0001;
      4'd4:    mem = 4'b0000;
      4'd5:    mem = 4'b1111;
      default: mem = a ^ 4'h5;
    endcase
  endfunction

  assign dado = mem(endereco);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".db"}, db_estado, 0);
    chk({tag, ".leds"}, leds, 0);
    chk({tag, ".ocup"}, ocupado, 0);
    chk({tag, ".pronto"}, pronto, 0);
  endtask

  // Full directed playback with checks every cycle.
  // inj: re-assert iniciar and change limite during item 1.
  task automatic play(input int L, input bit inj);
    limite  = 4'(L);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    cyc = 0;
    chk("prep.db", db_estado, 1);
    chk("prep.ocup", ocupado, 1);
    chk("prep.leds", leds, 0);
    for (int i = 0; i <= L; i++) begin
      for (int k = 0; k < TA; k++) begin
        tick(); cyc++;
        iniciar = 1'b0;
        chk("on.db", db_estado, 2);
        chk("on.addr", endereco, i);
        chk("on.leds", leds, mem(4'(i)));
        chk("on.pronto", pronto, 0);
        if (inj && i == 1 && k == 0) begin
          iniciar = 1'b1;
          limite  = 4'd7;
        end
      end
      for (int k = 0; k < TP; k++) begin
        tick(); cyc++;
        chk("off.db", db_estado, 3);
        chk("off.leds", leds, 0);
        chk("off.ocup", ocupado, 1);
      end
      if (i < L) begin
        tick(); cyc++;
        chk("nxt.db", db_estado, 4);
        chk("nxt.leds", leds, 0);
      end
    end
    tick(); cyc++;
    chk("fim.db", db_estado, 5);
    chk("fim.pronto", pronto, 1);
    chk("fim.addr", endereco, L);
    chk("fim.lat", cyc, 1 + (L + 1) * (TA + TP) + L);
    tick();
    chk_idle("post");
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("quiet.pronto", pronto, 0);
      chk("quiet.db", db_estado, 0);
    end
  endtask

  initial begin
    logic [3:0] seq [8];
    total   = 0;
    bad     = 0;
    reset   = 1'b0;
    iniciar = 1'b0;
    limite  = 4'd0;
    #3;
    chk_idle("rst0");
    chk("rst0.addr", endereco, 0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_idle("rst");
      chk("rst.addr", endereco, 0);
    end

    play(0, 1'b0);
    play(3, 1'b0);
    play(3, 1'b1);
    play(5, 1'b0);
    play(15, 1'b0);

    // Abort during APAGA of item 2
    limite  = 4'd3;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    repeat (16) tick();
    chk("ab.db", db_estado, 3);
    chk("ab.addr", endereco, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("ab.leds", leds, 0);
    chk("ab.db0", db_estado, 0);
    chk("ab.addr0", endereco, 0);
    chk("ab.ocup", ocupado, 0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("ab.pronto", pronto, 0);
    end

    // Held start: 8-cycle repeating run
    seq[0] = 4'd1; seq[1] = 4'd2; seq[2] = 4'd2; seq[3] = 4'd2;
    seq[4] = 4'd3; seq[5] = 4'd3; seq[6] = 4'd5; seq[7] = 4'd0;
    limite  = 4'd0;
    iniciar = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 8; k++) begin
        tick();
        chk("hold.db", db_estado, seq[k]);
        chk("hold.pronto", pronto, (k == 6) ? 1 : 0);
      end
    end
    iniciar = 1'b0;
    tick();
    chk("hold.end", db_estado, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exibe_sequencia.md
Name: exibe_sequencia

Overview:
- Output-side counterpart of the game's button-input path: plays the stored sequence back to the player on the LEDs before the player answers on `botoes`.
- Walks the sequence memory from address 0 to `limite`. Lights each stored one-hot code for a fixed on-time, then blanks for a fixed off-time.
- Pulses `pronto` when playback ends.
- Sits between the game control unit (which issues `iniciar` and `limite`) and the sequence ROM/RAM (read via `endereco`/`dado`).

Parameters:
- TEMPO_ACESO, 500, clock cycles each item is lit (500 ms at the 1 kHz game clock); must be >= 1.
- TEMPO_APAGADO, 250, clock cycles of blank gap after each item; must be >= 1.
- ADDR_W, 4, memory address width; sequence depth is 2**ADDR_W.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- iniciar  input  1  start request; level-sampled only in state INICIAL.
- limite  input  ADDR_W  index of the last item to show (0 means one item); sampled when `iniciar` is accepted.
- dado  input  4  memory read data for `endereco`; combinational read, valid in the same cycle.
- endereco  output  ADDR_W  memory read address (registered).
- leds  output  4  LED drive; equals `dado` in ACENDE, 0 otherwise.
- ocupado  output  1  high in every state except INICIAL.
- pronto  output  1  one-cycle pulse, high only in state FIM.
- db_estado  output  4  current state code, for the 7-segment debug display.

Behaviour:
- Reset (reset=0, async) forces:
  - state=INICIAL (code 0); endereco=0; limite register=0; timer=0.
  - leds=0, ocupado=0, pronto=0, db_estado=0.
  - Reset mid-playback aborts immediately; `pronto` is never emitted for the aborted run.
- States and codes: INICIAL=0, PREPARA=1, ACENDE=2, APAGA=3, PROXIMO=4, FIM=5. Codes 6-15 are unreachable and go to INICIAL on the next edge.
- INICIAL:
  - iniciar=1 -> PREPARA; `limite` is latched on that edge.
  - Otherwise stay in INICIAL.
- PREPARA: endereco<=0, timer<=0; -> ACENDE. Always exactly 1 cycle.
- ACENDE:
  - leds=dado.
  - timer increments each cycle.
  - When timer==TEMPO_ACESO-1: timer<=0, -> APAGA. The state lasts exactly TEMPO_ACESO cycles.
- APAGA:
  - leds=0.
  - Lasts exactly TEMPO_APAGADO cycles, same timer rule.
  - On exit: if endereco==limite (latched value) -> FIM, else -> PROXIMO.
- PROXIMO: endereco<=endereco+1, timer<=0; -> ACENDE. Always 1 cycle.
- FIM: pronto=1; -> INICIAL. Always 1 cycle.
- Timer:
  - Width is ceil(log2(max(TEMPO_ACESO, TEMPO_APAGADO)))+1 bits.
  - Cleared on every state change.
  - Never wraps within a state.
- Latency: from the edge that samples iniciar=1 to the `pronto` cycle = 1 + (L+1)*(TEMPO_ACESO+TEMPO_APAGADO) + L cycles, where L = latched limite.
- Boundary conditions:
  - `iniciar` is ignored outside INICIAL, and changes to `limite` after latching are ignored.
  - `iniciar` held high continuously: a new playback starts on the edge after FIM (INICIAL is occupied for one cycle).
  - `dado` is shown unmodified, even when it is not one-hot (0000 or multi-bit).
  - limite = 2**ADDR_W-1 plays the full memory. endereco never wraps because FIM is taken first.

Test Plan (TEMPO_ACESO=3, TEMPO_APAGADO=2, ADDR_W=4, memory holds 1000, 0100, 0010, 0001, ...):
- Reset:
  - Stimulus: reset=0 for 1 cycle, then reset=1 with iniciar=0 for 5 cycles.
  - Required: leds=0, endereco=0, ocupado=0, pronto=0, db_estado=0 throughout.
- Single item:
  - Stimulus: limite=0, iniciar pulsed for 1 cycle.
  - Required: PREPARA 1 cycle; leds=1000 for exactly 3 cycles; leds=0 for 2 cycles; pronto high 1 cycle. pronto occurs 6 cycles after the sampling edge.
- Four items:
  - Stimulus: limite=3, iniciar pulsed.
  - Required: leds show 1000, 0100, 0010, 0001 (3 cycles each) with 3 cycles of zeros between items (2 APAGA + 1 PROXIMO) and 2 cycles of zeros after the last item.
  - Required: endereco steps 0 to 3; pronto 24 cycles after the start edge.
- Ignored inputs:
  - Stimulus: iniciar re-asserted and limite changed to 7 during ACENDE of item 1.
  - Required: playback unaffected; still ends after item 3 with a single pronto.
- Reset mid-operation:
  - Stimulus: reset=0 asynchronously during APAGA of item 2.
  - Required: leds=0, db_estado=0, endereco=0 immediately (before the next edge); no pronto afterwards.
- Held iniciar:
  - Stimulus: iniciar held at 1 with limite=0.
  - Required: pronto pulses repeat every 8 cycles (6-cycle run + FIM→INICIAL + 1 INICIAL cycle); db_estado sequence 1,2,2,2,3,3,5,0 repeats.
